// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry holding register.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx #(
  parameter int CLK_PER_BIT = 434,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] CNT_LAST =
    16'(CLK_PER_BIT - 1);
  localparam logic [15:0] CNT_DONE =
    16'(CLK_PER_BIT - 2);
  localparam logic STOP_LAST =
    1'(STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  idx_nxt;
  logic        stop_idx;
  logic [7:0]  shift_reg;
  logic [7:0]  hold_reg;
  logic        hold_full;
  logic        hold_nxt;
  logic        accept;
  logic        consume;
  logic        bit_end;
  logic        last_stop;

  // Accept and consume never coincide:
  // accept needs an empty holding register.
  always_comb begin
    accept    = tx_valid & tx_ready;
    bit_end   = (clk_cnt == CNT_LAST);
    last_stop = (stop_idx == STOP_LAST);
    idx_nxt   = bit_idx + 3'd1;
    consume   = 1'b0;
    if (state == IDLE)
      consume = hold_full;
    else if (state == STOP)
      consume = hold_full & bit_end
              & last_stop;
    hold_nxt = hold_full;
    if (accept)
      hold_nxt = 1'b1;
    else if (consume)
      hold_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      hold_full <= hold_nxt;
      tx_ready  <= ~hold_nxt;
      tx_done   <= 1'b0;
      if (accept)
        hold_reg <= tx_data;
      if (state == IDLE || bit_end)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (hold_full) begin
            shift_reg <= hold_reg;
            state     <= START;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shift_reg;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= idx_nxt;
              tx      <= shift_reg[idx_nxt];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
`endif
        STOP: begin
          // Pulse lands on the final stop cycle.
          if (last_stop && clk_cnt == CNT_DONE)
            tx_done <= 1'b1;
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else if (hold_full) begin
              shift_reg <= hold_reg;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
